csd_conv_param: RTL and testbench
=================================

# csd_conv_param

Parametrised signed-digit to canonical-signed-digit (CSD / non-adjacent form) converter. Holds a DIGITS-entry input digit memory loaded by the host, converts it LSB-first at one digit per cycle into a DIGITS+1-entry result memory, and streams each result digit as it is produced. Generalises the fixed 4-digit binary converter to any digit count, accepts true signed-digit (ASD) input, flags invalid encodings, and reports the nonzero-digit weight.

## Interface
- DIGITS, 16: input digit count; result has DIGITS+1 digits.
- ADDR_W, 5: address/weight width; must satisfy 2^ADDR_W ≥ DIGITS+1.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch request; internally rising-edge detected.
- weCsd  in  1  write dataIn to input memory[address].
- address  in  ADDR_W  shared read/write digit index; index 0 = LSB.
- dataIn  in  2  input digit: 00 = 0, 01 = +1, 11 = −1, 10 = invalid.
- reCsd  in  1  read result memory[address] onto dataOut.
- dataOut  out  2  registered read data, same encoding.
- Zi  out  2  serial result digit for the current RUN cycle.
- Zvalid  out  1  Zi valid.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky invalid-encoding flag.
- weight  out  ADDR_W  nonzero-digit count (only with CSD_WEIGHT_EN).

## Operation
- Reset (reset = 0): state IDLE; idx, carry, start_q cleared; both memories cleared to 00; dataOut, Zi = 00; Zvalid, busy, done, err, weight = 0.
- Writes: accepted only in IDLE with address < DIGITS; otherwise ignored. A code of 10 is stored as 00 and sets err.
- Reads: reCsd in any state; address ≤ DIGITS returns result[address], otherwise 00. dataOut holds its value when reCsd = 0. Reads during RUN return partially updated contents.
- FSM:
  - IDLE: start & ~start_q → RUN; clears idx, carry, err, weight.
  - RUN: processes digit idx; result[idx] ← z; Zi = z; Zvalid = 1. When idx == DIGITS → DONE, else idx+1.
  - DONE: done = 1 for one cycle → IDLE.
- Digit step (a_i = input[i], 0 for i ≥ DIGITS; carry c ∈ {−1, 0, +1}):
  - t = a_i + c.
  - t even: z = 0, c' = t/2.
  - t odd: pick z ∈ {+1, −1} so that c' = (t − z)/2 makes c' + a_{i+1} even.
- The result is always NAF: no two adjacent nonzero digits. After digit DIGITS the carry is 0.
- Signed arithmetic uses a 3-bit two's-complement t; carry is 2-bit signed.

## Timing
- Start edge sampled at cycle T → digits 0..DIGITS emitted in cycles T+1..T+DIGITS+1 → done high in cycle T+DIGITS+2 → IDLE at T+DIGITS+3.
- result[i] is readable via reCsd from the cycle after digit i is processed; dataOut is valid one cycle after reCsd.
- Holding start high runs exactly one conversion. A new run needs start low for at least one cycle.
- Start edges during RUN or DONE are ignored.
- Reset asserted mid-run aborts immediately; all state returns to reset values. start_q resets to 0, so a start held high across reset release launches one run.
- weight and err hold their values after done until the next launch.

## Configuration
- CSD_WEIGHT_EN defined: the weight port and counter are present. Each nonzero z in RUN increments weight; the value is final in the done cycle.
- CSD_WEIGHT_EN undefined: no weight port and no counter; all other behaviour is identical.

## Structure
- Package csd_pkg holds:
  - Digit-code constants DIG_ZERO, DIG_POS, DIG_NEG, DIG_INV.
  - State enum IDLE, RUN, DONE.
  - The digit-decode function (code → signed value).
- Sub-module csd_digit_step is purely combinational: inputs a_i, a_{i+1}, carry; outputs z, carry_next.

## Test plan
- DIGITS = 16; write +1, +1, 0, +1 at addresses 0–3, rest 0 (value 11); start → result digits 0–4 = −1, 0, −1, 0, +1, digits 5–16 = 0; done at T+18; weight = 3.
- DIGITS = 8, all inputs +1 (value 255) → result[0] = −1, result[8] = +1, all others 0; weight = 2.
- ASD input +1, −1 at addresses 0–1 (value −1) → result[0] = −1, all others 0; weight = 1.
- Write code 10 at address 2 → err = 1 and stored digit is 0; next start clears err.
- Hold start high through done with weCsd pulses during RUN → exactly one done pulse and input memory unchanged.
- Assert reset at T+5 mid-run → all outputs 0 and memories cleared next cycle; a start held high across release launches one run.

Source files
------------

// File: rtl/csd_pkg.sv
// Shared digit codes, FSM states and digit decode for the CSD converter.
// Digit codes are 2-bit two's complement, so valid codes double as signed values.
package csd_pkg;
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b11;
  localparam logic [1:0] DIG_INV  = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic signed [1:0] dig_decode(input logic [1:0] code);
    return (code == DIG_INV) ? 2'sb00 : $signed(code);
  endfunction
endpackage

// File: rtl/csd_digit_step.sv
// One LSB-first NAF recoding step: a_i plus carry, looking ahead at a_{i+1}.
module csd_digit_step (
  input  logic signed [1:0] i_a,
  input  logic signed [1:0] i_a_nxt,
  input  logic signed [1:0] i_carry,
  output logic signed [1:0] o_z,
  output logic signed [1:0] o_carry
);
  logic signed [2:0] w_t;

  assign w_t = {i_a[1], i_a} + {i_carry[1], i_carry};

  // Odd t is +/-1: emit -t and carry t when the next digit is odd, so the
  // next sum becomes even and the output stays non-adjacent.
  always_comb begin
    o_z     = 2'sb00;
    o_carry = w_t[2:1];
    if (w_t[0]) begin
      if (i_a_nxt != 2'sb00) begin
        o_z     = 2'sb00 - w_t[1:0];
        o_carry = w_t[1:0];
      end else begin
        o_z     = w_t[1:0];
        o_carry = 2'sb00;
      end
    end
  end
endmodule

// File: rtl/csd_conv_param.sv
// Signed-digit to CSD converter: DIGITS-entry input memory, serial LSB-first
// conversion into a DIGITS+1-entry result memory. CSD_WEIGHT_EN adds the weight counter.
module csd_conv_param
  import csd_pkg::*;
#(
  parameter int DIGITS = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              weCsd,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        dataIn,
  input  logic              reCsd,
  output logic [1:0]        dataOut,
  output logic [1:0]        Zi,
  output logic              Zvalid,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef CSD_WEIGHT_EN
  , output logic [ADDR_W-1:0] weight
`endif
);
  state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_idx;
  logic signed [1:0]     r_carry;
  logic                  r_start_q;
  logic [DIGITS-1:0][1:0] r_in_mem;
  logic [DIGITS:0][1:0]  r_res_mem;
  logic signed [1:0]     w_a, w_a_nxt, w_z, w_carry_nxt;
  logic [1:0]            w_rd;
  logic                  w_launch;

  assign w_launch = start & ~r_start_q;

  // Digits beyond the input memory read as zero.
  always_comb begin
    w_a     = 2'sb00;
    w_a_nxt = 2'sb00;
    w_rd    = DIG_ZERO;
    for (int k = 0; k < DIGITS; k++)
      if (r_idx == ADDR_W'(k)) w_a = dig_decode(r_in_mem[k]);
    for (int k = 1; k < DIGITS; k++)
      if (r_idx == ADDR_W'(k - 1)) w_a_nxt = dig_decode(r_in_mem[k]);
    for (int k = 0; k <= DIGITS; k++)
      if (address == ADDR_W'(k)) w_rd = r_res_mem[k];
  end

  csd_digit_step u_step (
    .i_a     (w_a),
    .i_a_nxt (w_a_nxt),
    .i_carry (r_carry),
    .o_z     (w_z),
    .o_carry (w_carry_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    Zvalid      = 1'b0;
    Zi          = DIG_ZERO;
    case (r_state)
      IDLE: if (w_launch) w_state_nxt = RUN;
      RUN: begin
        busy   = 1'b1;
        Zvalid = 1'b1;
        Zi     = w_z;
        if (r_idx == ADDR_W'(DIGITS)) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx     <= '0;
      r_carry   <= 2'sb00;
      r_start_q <= 1'b0;
      r_in_mem  <= '0;
      r_res_mem <= '0;
      dataOut   <= DIG_ZERO;
      err       <= 1'b0;
    end else begin
      r_start_q <= start;
      if (reCsd) dataOut <= w_rd;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_idx   <= '0;
            r_carry <= 2'sb00;
            err     <= 1'b0;
          end
          if (weCsd && address < ADDR_W'(DIGITS)) begin
            for (int k = 0; k < DIGITS; k++)
              if (address == ADDR_W'(k))
                r_in_mem[k] <= (dataIn == DIG_INV) ? DIG_ZERO : dataIn;
            if (dataIn == DIG_INV) err <= 1'b1;
          end
        end
        RUN: begin
          for (int k = 0; k <= DIGITS; k++)
            if (r_idx == ADDR_W'(k)) r_res_mem[k] <= w_z;
          r_carry <= w_carry_nxt;
          r_idx   <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CSD_WEIGHT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            weight <= '0;
    else if (r_state == IDLE && w_launch)  weight <= '0;
    else if (r_state == RUN && w_z != 2'sb00) weight <= weight + 1'b1;
  end
`endif
endmodule

// File: tb/tb_csd_conv_param.sv
// Directed bench for csd_conv_param; a value-level NAF model predicts the stream.
module tb_csd_conv_param;
  localparam int DIGITS = 16;
  localparam int ADDR_W = 5;

  logic              clk, reset, start, weCsd, reCsd;
  logic [ADDR_W-1:0] address;
  logic [1:0]        dataIn, dataOut, Zi;
  logic              Zvalid, busy, done, err;
`ifdef CSD_WEIGHT_EN
  logic [ADDR_W-1:0] weight;
`endif

  csd_conv_param #(.DIGITS(DIGITS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .weCsd(weCsd), .address(address),
    .dataIn(dataIn), .reCsd(reCsd), .dataOut(dataOut), .Zi(Zi), .Zvalid(Zvalid),
    .busy(busy), .done(done), .err(err)
`ifdef CSD_WEIGHT_EN
    , .weight(weight)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;
  int in_val [DIGITS];
  int exp_z [DIGITS+1];
  int exp_w = 0;
  int launch_cyc = -1000;

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
  endtask

  function automatic logic [1:0] enc(input int z);
    logic [31:0] v;
    v = z;
    return v[1:0];
  endfunction

  // Value-level model: sum the signed digits, then take the NAF of the integer.
  function automatic void build_exp();
    int v, z;
    v = 0;
    for (int i = 0; i < DIGITS; i++) v += in_val[i] * (1 << i);
    exp_w = 0;
    for (int i = 0; i <= DIGITS; i++) begin
      z = 0;
      if (v % 2 != 0) z = ((v & 3) == 1) ? 1 : -1;
      exp_z[i] = z;
      v = (v - z) / 2;
      if (z != 0) exp_w++;
    end
  endfunction

  always @(negedge clk) begin
    int n;
    n = cyc - launch_cyc;
    if (!reset) begin
      chk("rst_zvalid", int'(Zvalid), 0);
      chk("rst_busy",   int'(busy), 0);
      chk("rst_done",   int'(done), 0);
      chk("rst_zi",     int'(Zi), 0);
      chk("rst_dout",   int'(dataOut), 0);
      chk("rst_err",    int'(err), 0);
    end else begin
      chk("zvalid", int'(Zvalid), (n >= 0 && n <= DIGITS) ? 1 : 0);
      chk("busy",   int'(busy),   (n >= 0 && n <= DIGITS + 1) ? 1 : 0);
      chk("done",   int'(done),   (n == DIGITS + 1) ? 1 : 0);
      if (n >= 0 && n <= DIGITS) chk($sformatf("zi[%0d]", n), int'(Zi), int'(enc(exp_z[n])));
      else chk("zi_idle", int'(Zi), 0);
`ifdef CSD_WEIGHT_EN
      if (n == DIGITS + 1) chk("weight", int'(weight), exp_w);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input logic [1:0] code, input bit idle);
    weCsd = 1'b1; address = ADDR_W'(a); dataIn = code;
    tick();
    weCsd = 1'b0;
    if (idle && a < DIGITS) in_val[a] = (code == 2'b10) ? 0 : ((code == 2'b11) ? -1 : int'(code));
  endtask

  task automatic launch();
    start = 1'b1;
    launch_cyc = cyc + 1;
    build_exp();
    tick();
  endtask

  task automatic rd(input int a, input int expv, input string nm);
    reCsd = 1'b1; address = ADDR_W'(a);
    tick();
    reCsd = 1'b0;
    chk(nm, int'(dataOut), expv);
  endtask

  task automatic rd_all();
    for (int a = 0; a <= DIGITS; a++) rd(a, int'(enc(exp_z[a])), $sformatf("res[%0d]", a));
  endtask

  initial begin
    for (int i = 0; i < DIGITS; i++) in_val[i] = 0;
    build_exp();
    reset = 1'b0; start = 1'b0; weCsd = 1'b0; reCsd = 1'b0; address = '0; dataIn = 2'b00;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Value 11 -> -1,0,-1,0,+1
    wr(0, 2'b01, 1); wr(1, 2'b01, 1); wr(2, 2'b00, 1); wr(3, 2'b01, 1);
    launch(); start = 1'b0;
    repeat (DIGITS + 3) tick();
    rd(0, 3, "t1_r0"); rd(1, 0, "t1_r1"); rd(2, 3, "t1_r2");
    rd(3, 0, "t1_r3"); rd(4, 1, "t1_r4"); rd(16, 0, "t1_r16");
    reCsd = 1'b0; address = 5'd4;
    tick();
    chk("dout_hold", int'(dataOut), 0);
    rd(20, 0, "rd_oob");
    rd_all();
`ifdef CSD_WEIGHT_EN
    chk("t1_weight_hold", int'(weight), 3);
`endif

    // Value 255 -> -1 at 0, +1 at 8
    for (int i = 0; i < 8; i++) wr(i, 2'b01, 1);
    launch(); start = 1'b0;
    repeat (DIGITS + 3) tick();
    rd(0, 3, "t2_r0"); rd(8, 1, "t2_r8"); rd(4, 0, "t2_r4");
    rd_all();

    // ASD +1,-1 -> value -1
    for (int i = 2; i < 8; i++) wr(i, 2'b00, 1);
    wr(0, 2'b01, 1); wr(1, 2'b11, 1);
    launch(); start = 1'b0;
    repeat (DIGITS + 3) tick();
    rd(0, 3, "t3_r0"); rd(1, 0, "t3_r1");
    rd_all();

    // Invalid code sets err, stores zero; next launch clears err
    wr(2, 2'b10, 1);
    chk("err_set", int'(err), 1);
    tick();
    chk("err_sticky", int'(err), 1);
    launch();
    chk("err_clr", int'(err), 0);
    start = 1'b0;
    repeat (DIGITS + 3) tick();
    rd(2, 0, "t4_r2");
    rd_all();

    // Start held through done, writes during RUN ignored, mid-run start edge ignored
    launch();
    wr(5, 2'b01, 0);
    wr(6, 2'b11, 0);
    start = 1'b0; tick(); start = 1'b1;
    repeat (DIGITS + 6) tick();
    start = 1'b0; tick();
    launch(); start = 1'b0;
    repeat (DIGITS + 3) tick();
    rd_all();

    // Reset mid-run aborts; start held across release launches once
    launch();
    repeat (4) tick();
    reset = 1'b0;
    launch_cyc = -1000;
    for (int i = 0; i < DIGITS; i++) in_val[i] = 0;
    tick();
    chk("abort_dout", int'(dataOut), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_busy", int'(busy), 0);
    tick();
    reset = 1'b1;
    launch_cyc = cyc + 1;
    build_exp();
    tick();
    repeat (DIGITS + 6) tick();
    start = 1'b0;
    rd_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
